// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = $clog2(MDU_ITER);

endpackage

// File: rtl/mdu_negate32.sv
// Conditional 32-bit two's-complement negate; purely combinational.
module mdu_negate32 (
    input  logic [31:0] in,
    input  logic        en,
    output logic [31:0] out
);

    assign out = en ? (~in + 32'd1) : in;

endmodule

// File: rtl/mips_mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle on an unsigned core.
// Start is sampled at E0, HI/LO are written at E32, and done pulses for one cycle; start is ignored while busy.
module mips_mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, neg_res_q, neg_rem_q, rt_zero_q, dbz_q;
    logic [WIDTH-1:0]   b_q, rs_q, rem_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc_q;

    logic               accept, last;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     sum, part_rem;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt, quo_raw, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CNT_W'(MDU_ITER - 1));

    mdu_negate32 u_mag_rs (.in(rs), .en(op[0] & rs[WIDTH-1]), .out(rs_mag));
    mdu_negate32 u_mag_rt (.in(rt), .en(op[0] & rt[WIDTH-1]), .out(rt_mag));

    // Multiply: low half shifts the multiplier out while the product fills in from the top.
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {sum, acc_q[WIDTH-1:1]};

    // Divide: {rem_q, next dividend bit} is the 33-bit partial remainder of the restoring step.
    assign part_rem = {rem_q, acc_q[WIDTH-1]};
    assign ge       = part_rem >= {1'b0, b_q};
    assign rem_nxt  = ge ? (part_rem[WIDTH-1:0] - b_q) : part_rem[WIDTH-1:0];
    assign quo_raw  = {acc_q[WIDTH-2:0], ge};
    assign div_nxt  = {acc_q[2*WIDTH-1:WIDTH], quo_raw};
    assign acc_nxt  = is_div_q ? div_nxt : mul_nxt;

    mdu_negate32 u_fix_quo (.in(quo_raw), .en(neg_res_q), .out(quo_fix));
    mdu_negate32 u_fix_rem (.in(rem_nxt), .en(neg_rem_q), .out(rem_fix));

    assign prod_fix = neg_res_q ? (~mul_nxt + 64'd1) : mul_nxt;

    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (rt_zero_q) begin
                hi_res = rs_q;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rt_zero_q <= 1'b0;
            dbz_q     <= 1'b0;
            b_q       <= '0;
            rs_q      <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_res_q <= op[0] & (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_rem_q <= op[0] & rs[WIDTH-1];
            rt_zero_q <= (rt == '0);
            b_q       <= rt_mag;
            rs_q      <= rs;
            rem_q     <= '0;
            acc_q     <= {{WIDTH{1'b0}}, rs_mag};
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_nxt;
            rem_q <= rem_nxt;
            if (last) begin
                hi_q  <= hi_res;
                lo_q  <= lo_res;
                dbz_q <= is_div_q & rt_zero_q;
            end
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = done & dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_mult_div_unit.sv
// Directed-vector bench for mips_mult_div_unit with hand-computed HI/LO results.
module tb_mips_mult_div_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] rs    = '0;
    logic [31:0] rt    = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int lat, busy_n;

    always #5 clk = ~clk;

    mips_mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cycles++;
            step(1);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int l, bn;
        issue(o, a, b);
        wait_done(l, bn);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        step(1);
        check({tag, "_dbz_after"}, {31'b0, div_by_zero}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        #10 rst_n = 1'b1;
        step(1);

        // Latency and busy width on the largest unsigned product.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", {31'b0, busy}, 32'd1);
        wait_done(lat, busy_n);
        check("multu_latency", lat, 32'd32);
        check("multu_busy_cycles", busy_n, 32'd32);
        check("multu_busy_in_done", {31'b0, busy}, 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_dbz", {31'b0, div_by_zero}, 32'd0);
        step(1);
        check("multu_done_one_cycle", {31'b0, done}, 32'd0);

        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_wrap", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero_neg", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // A second start mid-RUN with different operands must not disturb the operation.
        issue(2'b00, 32'd3, 32'd4);
        step(5);
        issue(2'b10, 32'd9, 32'd4);
        wait_done(lat, busy_n);
        check("restart_ignored_done", {31'b0, done}, 32'd1);
        check("restart_ignored_hi", hi, 32'd0);
        check("restart_ignored_lo", lo, 32'd12);

        // Back-to-back: start asserted in the DONE cycle.
        issue(2'b00, 32'd2, 32'd2);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(lat, busy_n);
        check("b2b_latency", lat, 32'd32);
        check("b2b_lo", lo, 32'd4);
        step(1);

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'd1000, 32'd3);
        step(10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        #3 rst_n = 1'b1;
        step(1);
        run_op("post_rst_multu", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
